// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall sequencer: the per-stage control
// bundle and the sequencer state encoding.
package stage_ports;

    typedef struct packed {
        logic load_pc;
        logic load_ifid;
        logic flush_ifid;
        logic load_idex;
        logic flush_idex;
        logic load_exmem;
        logic load_memwb;
    } pipe_ctrl_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DROP  = 2'd1,
        REDIR = 2'd2
    } ctrl_state_e;

    localparam pipe_ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: the ID instruction reads a register that a load in EX
// has not produced yet. Purely combinational so the forwarding unit can share it.
module hazard_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_is_load,
    output logic       lu_haz
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    // x0 is hardwired to zero, so a load "into" x0 never creates a dependency
    assign lu_haz  = ex_is_load && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and stall sequencer for the 5-stage RV32I pipeline: PC/pipeline-register
// load and flush controls, deferred branch redirect, and saturating perf counters.
module pipeline_ctrl
    import stage_ports::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_br_taken,
    input  logic [31:0]      ex_br_target,
    output logic             load_pc,
    output logic             pc_redirect,
    output logic [31:0]      pc_target,
    output logic             load_ifid,
    output logic             flush_ifid,
    output logic             load_idex,
    output logic             flush_idex,
    output logic             load_exmem,
    output logic             load_memwb,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_e      state_reg, state_next;
    logic [31:0]      tgt_reg, tgt_next;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
    pipe_ctrl_t       ctrl;
    logic             redirect;
    logic [31:0]      target;
    logic             flush_inc;
    logic             imem_busy;
    logic             dmem_busy;
    logic             lu_haz;

    assign imem_busy = imem_read && !imem_resp;
    assign dmem_busy = dmem_req && !dmem_resp;

    hazard_detect u_hazard (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_is_load  (ex_is_load),
        .lu_haz      (lu_haz)
    );

    always_comb begin
        ctrl       = CTRL_NONE;
        redirect   = 1'b0;
        target     = tgt_reg;
        state_next = state_reg;
        tgt_next   = tgt_reg;
        flush_inc  = 1'b0;
        case (state_reg)
            RUN: begin
                if (dmem_busy) begin
                    ctrl = CTRL_NONE;
                end else if (ex_br_taken && !imem_busy) begin
                    ctrl      = '1;
                    redirect  = 1'b1;
                    target    = ex_br_target;
                    flush_inc = 1'b1;
                end else if (ex_br_taken) begin
                    // Fetch in flight: park the target, squash, and drain the stale fetch
                    ctrl            = '1;
                    ctrl.load_pc    = 1'b0;
                    tgt_next        = ex_br_target;
                    flush_inc       = 1'b1;
                    state_next      = DROP;
                end else if (imem_busy || lu_haz) begin
                    ctrl.flush_idex = 1'b1;
                    ctrl.load_idex  = 1'b1;
                    ctrl.load_exmem = 1'b1;
                    ctrl.load_memwb = 1'b1;
                end else begin
                    ctrl.load_pc    = 1'b1;
                    ctrl.load_ifid  = 1'b1;
                    ctrl.load_idex  = 1'b1;
                    ctrl.load_exmem = 1'b1;
                    ctrl.load_memwb = 1'b1;
                end
            end
            DROP: begin
                ctrl.flush_idex = 1'b1;
                ctrl.load_idex  = 1'b1;
                ctrl.load_exmem = !dmem_busy;
                ctrl.load_memwb = !dmem_busy;
                if (imem_resp) begin
                    state_next = REDIR;
                end
            end
            REDIR: begin
                if (!dmem_busy) begin
                    ctrl.load_pc    = 1'b1;
                    ctrl.flush_idex = 1'b1;
                    ctrl.load_idex  = 1'b1;
                    ctrl.load_exmem = 1'b1;
                    ctrl.load_memwb = 1'b1;
                    redirect        = 1'b1;
                    state_next      = RUN;
                end
            end
            default: state_next = RUN;
        endcase
        if (rst) begin
            ctrl     = CTRL_NONE;
            redirect = 1'b0;
            target   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= RUN;
            tgt_reg       <= '0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            tgt_reg   <= tgt_next;
            if (!ctrl.load_ifid && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (flush_inc && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign load_pc     = ctrl.load_pc;
    assign load_ifid   = ctrl.load_ifid;
    assign flush_ifid  = ctrl.flush_ifid;
    assign load_idex   = ctrl.load_idex;
    assign flush_idex  = ctrl.flush_idex;
    assign load_exmem  = ctrl.load_exmem;
    assign load_memwb  = ctrl.load_memwb;
    assign pc_redirect = redirect;
    assign pc_target   = target;
    assign stall_cnt   = stall_cnt_reg;
    assign flush_cnt   = flush_cnt_reg;

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and stall sequencer for the 5-stage RV32I pipeline.
- Generates the load and flush controls for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use hazards, memory wait stalls and EX-stage branch redirects, including a redirect that arrives while an instruction fetch is outstanding.
- Maintains stall and flush performance counters.

Parameters:
CNT_W, 32, width of the saturating performance counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
imem_read  in  1  fetch request outstanding
imem_resp  in  1  fetch data valid this cycle
dmem_req  in  1  MEM-stage load/store outstanding
dmem_resp  in  1  data memory response this cycle
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination of instruction in EX
ex_is_load  in  1  EX instruction is a load
ex_br_taken  in  1  EX resolved a taken branch/jump
ex_br_target  in  32  redirect target (rv32i_word)
load_pc  out  1  PC register enable
pc_redirect  out  1  PC mux selects pc_target
pc_target  out  32  redirect address
load_ifid  out  1  IF/ID enable
flush_ifid  out  1  IF/ID loads NOP/invalid
load_idex  out  1  ID/EX enable
flush_idex  out  1  ID/EX loads bubble
load_exmem  out  1  EX/MEM enable
load_memwb  out  1  MEM/WB enable
stall_cnt  out  CNT_W  cycles with load_ifid=0
flush_cnt  out  CNT_W  redirects taken

Behaviour:
Derived signals:
- imem_busy = imem_read & ~imem_resp.
- dmem_busy = dmem_req & ~dmem_resp.
- lu_haz = ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).

Reset and general rules:
- Reset (async): state=RUN, tgt_q=0, both counters=0.
- While rst is asserted, all load_*, flush_*, pc_redirect=0 and pc_target=0.
- Outputs are combinational from the state and the current inputs, with zero latency.

FSM states: RUN, DROP, REDIR.

RUN, priority order:
1. dmem_busy: all load_*=0, no flush; the whole pipe is frozen. Redirect and lu_haz are deferred, because EX holds.
2. ex_br_taken & ~imem_busy: load_pc=1, pc_redirect=1, pc_target=ex_br_target, flush_ifid=1, flush_idex=1, all load_*=1, flush_cnt++.
3. ex_br_taken & imem_busy: tgt_q<=ex_br_target, load_pc=0, flush_ifid=1, load_ifid=1, flush_idex=1, load_idex/exmem/memwb=1, flush_cnt++, next state DROP.
4. imem_busy: load_pc=0, load_ifid=0, flush_idex=1 (bubble), load_idex/exmem/memwb=1.
5. lu_haz: load_pc=0, load_ifid=0, flush_idex=1, load_idex/exmem/memwb=1. This is exactly one bubble cycle.
6. Otherwise: all load_*=1, no flush.

DROP (discarding the stale fetch):
- load_pc=0, load_ifid=0, flush_idex=1, load_idex=1.
- load_exmem/memwb = ~dmem_busy.
- On imem_resp, the data is discarded and the next state is REDIR, even if dmem_busy.
- ex_br_taken is ignored; EX holds only bubbles, so an asserted ex_br_taken here is a bench assertion failure.

REDIR:
- If dmem_busy: all load_*=0 and stay in REDIR.
- Else: load_pc=1, pc_redirect=1, pc_target=tgt_q, load_ifid=0, flush_idex=1, load_idex/exmem/memwb=1, next state RUN.

Whenever pc_redirect=0, pc_target=tgt_q.

Counters:
- stall_cnt increments on every non-reset cycle with load_ifid=0.
- Both counters saturate at all-ones and do not wrap.

Reset mid-DROP/REDIR: returns to RUN; the pending redirect is lost (the pipeline is also reset).

Decomposition:
- stage_ports package: pipe_ctrl_t struct (load_pc, load_ifid, flush_ifid, load_idex, flush_idex, load_exmem, load_memwb) and ctrl_state_e enum {RUN, DROP, REDIR}.
- One sub-module, hazard_detect: purely combinational lu_haz computation, reused by the forwarding unit.

Test Plan:
1. Load x5 in EX, add x6,x5,x1 in ID, memories idle -> one cycle with load_pc=0, load_ifid=0, flush_idex=1; stall_cnt=1; the next cycle is all-load.
2. Same as 1 but ex_rd=0 -> no stall, all load_*=1.
3. ex_br_taken with ex_br_target=0x60 and imem idle -> same cycle pc_redirect=1, pc_target=0x60, flush_ifid=flush_idex=1; flush_cnt=1.
4. ex_br_taken with target 0x80 while imem_busy; imem_resp 3 cycles later -> DROP for 3 cycles with load_pc=0, fetch discarded; in REDIR, pc_redirect=1, pc_target=0x80; then RUN.
5. dmem_req held 4 cycles with lu_haz and ex_br_taken asserted -> all load_*=0 for 4 cycles; on the dmem_resp cycle the redirect is applied; stall_cnt=+4 minimum.
6. Assert rst while in DROP -> outputs 0 immediately, state RUN and counters 0 after release; a forced counter at all-ones plus a stall stays at all-ones.
